// File: rtl/ex_mem_stage.sv
// EX stage with EX/MEM pipeline register: single-cycle ALU ops plus a
// 32-step shift-add MULTU that stalls the front of the pipe and fills HI/LO.
module ex_mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  WB_in,
   input  logic [1:0]  M_in,
   input  logic [4:0]  EX_in,
   input  logic [31:0] RTdata_in,
   input  logic [31:0] srcl_in,
   input  logic [4:0]  shamt_in,
   input  logic [31:0] se_in,
   input  logic [4:0]  R_add_in,
   input  logic [4:0]  I_add_in,
   output logic        stall,
   output logic [1:0]  WB_out,
   output logic [1:0]  M_out,
   output logic [31:0] ALU_out,
   output logic [31:0] RTdata_out,
   output logic [4:0]  W_add_out,
   output logic [31:0] HI_out,
   output logic [31:0] LO_out
);

   // state | meaning
   // IDLE  | single-cycle ops retire; MULTU is accepted and operands latched
   // MUL   | one shift-add step per cycle, 32 steps, pipe stalled
   // DONE  | MULTU retires as a bubble, stall released
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   localparam logic [2:0] OP_MULTU = 3'b110;

   state_t      state, state_nxt;
   logic        reg_dst, alu_src;
   logic [2:0]  alu_op;
   logic [31:0] b_op, alu_res;
   logic [4:0]  dest;
   logic        load, start, step;
   logic [63:0] mcand, acc, acc_sum;
   logic [31:0] mplier, hi, lo;
   logic [4:0]  cnt;

   assign reg_dst = EX_in[4];
   assign alu_src = EX_in[3];
   assign alu_op  = EX_in[2:0];
   assign b_op    = alu_src ? se_in : RTdata_in;
   assign dest    = reg_dst ? R_add_in : I_add_in;
   assign acc_sum = acc + (mplier[0] ? mcand : 64'd0);
   assign HI_out  = hi;
   assign LO_out  = lo;

   always_comb begin
      alu_res = 32'd0;
      case (alu_op)
         3'b000: alu_res = srcl_in + b_op;
         3'b001: alu_res = srcl_in - b_op;
         3'b010: alu_res = srcl_in & b_op;
         3'b011: alu_res = srcl_in | b_op;
         3'b100: alu_res = {31'd0, $signed(srcl_in) < $signed(b_op)};
         3'b101: alu_res = b_op << shamt_in;
         3'b111: alu_res = lo;
         default: alu_res = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      load      = 1'b0;
      start     = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            if (alu_op == OP_MULTU) begin
               stall     = 1'b1;
               start     = 1'b1;
               state_nxt = MUL;
            end else begin
               load = 1'b1;
            end
         end
         MUL: begin
            stall = 1'b1;
            step  = 1'b1;
            if (cnt == 5'd31) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= 64'd0;
         mplier <= 32'd0;
         acc    <= 64'd0;
         cnt    <= 5'd0;
         hi     <= 32'd0;
         lo     <= 32'd0;
      end else if (start) begin
         mcand  <= {32'd0, srcl_in};
         mplier <= b_op;
         acc    <= 64'd0;
         cnt    <= 5'd0;
      end else if (step) begin
         acc    <= acc_sum;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 5'd1;
         if (cnt == 5'd31) begin
            hi <= acc_sum[63:32];
            lo <= acc_sum[31:0];
         end
      end
   end

   // Every cycle a MULTU occupies writes a bubble into EX/MEM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         WB_out     <= 2'd0;
         M_out      <= 2'd0;
         ALU_out    <= 32'd0;
         RTdata_out <= 32'd0;
         W_add_out  <= 5'd0;
      end else if (load) begin
         WB_out     <= WB_in;
         M_out      <= M_in;
         ALU_out    <= alu_res;
         RTdata_out <= RTdata_in;
         W_add_out  <= dest;
      end else begin
         WB_out     <= 2'd0;
         M_out      <= 2'd0;
         ALU_out    <= 32'd0;
         RTdata_out <= 32'd0;
         W_add_out  <= 5'd0;
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed and randomized checks of ex_mem_stage against an arithmetic
// reference model of the ALU, the EX/MEM register and the MULTU timing.
module tb_ex_mem_stage;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  WB_in, M_in;
   logic [4:0]  EX_in;
   logic [31:0] RTdata_in, srcl_in, se_in;
   logic [4:0]  shamt_in, R_add_in, I_add_in;
   logic        stall;
   logic [1:0]  WB_out, M_out;
   logic [31:0] ALU_out, RTdata_out, HI_out, LO_out;
   logic [4:0]  W_add_out;

   int checks = 0;
   int failures = 0;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

   ex_mem_stage dut (
      .clk(clk), .rst_n(rst_n),
      .WB_in(WB_in), .M_in(M_in), .EX_in(EX_in),
      .RTdata_in(RTdata_in), .srcl_in(srcl_in), .shamt_in(shamt_in),
      .se_in(se_in), .R_add_in(R_add_in), .I_add_in(I_add_in),
      .stall(stall), .WB_out(WB_out), .M_out(M_out), .ALU_out(ALU_out),
      .RTdata_out(RTdata_out), .W_add_out(W_add_out),
      .HI_out(HI_out), .LO_out(LO_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_alu(input int op, input logic [31:0] a,
                                             input logic [31:0] b, input int sh);
      case (op)
         0: return a + b;
         1: return a - b;
         2: return a & b;
         3: return a | b;
         4: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         5: return b << sh;
         7: return m_lo;
         default: return 32'd0;
      endcase
   endfunction

   task automatic set_in(input logic [1:0] wb, input logic [1:0] m, input logic [4:0] ex,
                         input logic [31:0] rt, input logic [31:0] a, input logic [4:0] sh,
                         input logic [31:0] se, input logic [4:0] radd, input logic [4:0] iadd);
      WB_in = wb; M_in = m; EX_in = ex; RTdata_in = rt; srcl_in = a;
      shamt_in = sh; se_in = se; R_add_in = radd; I_add_in = iadd;
   endtask

   // Single-cycle op: apply, expect no stall, one edge later the result.
   task automatic do_op(input string tag, input logic [1:0] wb, input logic [1:0] m,
                        input logic [4:0] ex, input logic [31:0] rt, input logic [31:0] a,
                        input logic [4:0] sh, input logic [31:0] se,
                        input logic [4:0] radd, input logic [4:0] iadd);
      logic [31:0] b, res;
      logic [4:0]  d;
      set_in(wb, m, ex, rt, a, sh, se, radd, iadd);
      b   = ex[3] ? se : rt;
      d   = ex[4] ? radd : iadd;
      res = model_alu(int'(ex[2:0]), a, b, int'(sh));
      #1 check({tag, ".stall"}, {63'd0, stall}, 64'd0);
      @(posedge clk); #1;
      check({tag, ".alu"}, {32'd0, ALU_out}, {32'd0, res});
      check({tag, ".ctl"}, {32'd0, 16'd0, 2'd0, WB_out, M_out, W_add_out, RTdata_out[31:27]},
            {32'd0, 16'd0, 2'd0, wb, m, d, rt[31:27]});
      check({tag, ".rtdata"}, {32'd0, RTdata_out}, {32'd0, rt});
      check({tag, ".hilo"}, {HI_out, LO_out}, {m_hi, m_lo});
   endtask

   task automatic do_mult(input string tag, input logic [4:0] ex, input logic [31:0] rt,
                          input logic [31:0] a, input logic [31:0] se, input bit scramble);
      logic [31:0] b;
      logic [63:0] prod;
      b    = ex[3] ? se : rt;
      prod = {32'd0, a} * {32'd0, b};
      set_in(2'b10, 2'b01, ex, rt, a, 5'd3, se, 5'd7, 5'd8);
      for (int c = 0; c < 34; c++) begin
         if (scramble && c >= 1 && c <= 32) begin
            srcl_in = $urandom; RTdata_in = $urandom; se_in = $urandom;
         end else if (c == 33) begin
            srcl_in = a; RTdata_in = rt; se_in = se;
         end
         #1 check({tag, ".stall"}, {63'd0, stall}, {63'd0, c < 33});
         @(posedge clk); #1;
         check({tag, ".bubble"}, {ALU_out, RTdata_out},
               64'd0);
         check({tag, ".bubble_ctl"}, {55'd0, WB_out, M_out, W_add_out}, 64'd0);
         if (c == 31 || c == 33)
            check({tag, ".hilo"}, {HI_out, LO_out}, (c == 31) ? {m_hi, m_lo} : prod);
      end
      m_hi = prod[63:32];
      m_lo = prod[31:0];
   endtask

   initial begin
      int op;
      logic [4:0] ex;
      rst_n = 1'b0;
      set_in(2'b10, 2'b00, 5'b00000, 32'd7, 32'd5, 5'd0, 32'd0, 5'd3, 5'd0);
      #2;
      check("reset.outs", {ALU_out, RTdata_out}, 64'd0);
      check("reset.ctl", {55'd0, WB_out, M_out, W_add_out}, 64'd0);
      check("reset.hilo", {HI_out, LO_out}, 64'd0);
      check("reset.stall", {63'd0, stall}, 64'd0);
      #1 rst_n = 1'b1;

      do_op("add", 2'b10, 2'b00, 5'b00000, 32'd7, 32'd5, 5'd0, 32'd0, 5'd3, 5'd0);
      do_op("slt_imm", 2'b10, 2'b00, 5'b01100, 32'd0, 32'hFFFF_FFFF, 5'd0, 32'd1, 5'd0, 5'd9);
      do_op("sll", 2'b10, 2'b00, 5'b00101, 32'd1, 32'd0, 5'd31, 32'd0, 5'd0, 5'd2);
      do_op("add_wrap", 2'b10, 2'b00, 5'b10000, 32'd1, 32'h7FFF_FFFF, 5'd0, 32'd0, 5'd6, 5'd0);
      do_op("sub_wrap", 2'b10, 2'b00, 5'b10001, 32'd1, 32'd0, 5'd0, 32'd0, 5'd6, 5'd0);
      do_op("sw_and", 2'b00, 2'b10, 5'b01010, 32'hDEAD_BEEF, 32'hF0F0_1234, 5'd0, 32'h0FF0_FF00, 5'd0, 5'd11);

      do_mult("multu_max", 5'b00110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1);
      check("multu_max.hi", {32'd0, HI_out}, 64'h0000_0000_FFFF_FFFE);
      check("multu_max.lo", {32'd0, LO_out}, 64'h0000_0000_0000_0001);
      do_op("mflo", 2'b10, 2'b00, 5'b10111, 32'd0, 32'd0, 5'd0, 32'd0, 5'd4, 5'd0);
      do_mult("multu_imm", 5'b01110, 32'd0, 32'h1234_5678, 32'h9ABC_DEF1, 1'b0);
      do_op("mflo_imm", 2'b10, 2'b00, 5'b10111, 32'd0, 32'd0, 5'd0, 32'd0, 5'd12, 5'd0);

      // Abort a multiply at step count 10 with an asynchronous reset.
      set_in(2'b10, 2'b00, 5'b00110, 32'h0001_0003, 32'h0007_0005, 5'd0, 32'd0, 5'd1, 5'd1);
      repeat (11) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("abort.outs", {ALU_out, RTdata_out}, 64'd0);
      check("abort.ctl", {55'd0, WB_out, M_out, W_add_out}, 64'd0);
      check("abort.hilo", {HI_out, LO_out}, 64'd0);
      check("abort.stall_multu", {63'd0, stall}, 64'd1);
      EX_in = 5'b00000;
      #1 check("abort.stall_add", {63'd0, stall}, 64'd0);
      m_hi = 32'd0; m_lo = 32'd0;
      rst_n = 1'b1;
      do_op("post_abort_add", 2'b10, 2'b00, 5'b10000, 32'd7, 32'd5, 5'd0, 32'd0, 5'd3, 5'd0);
      do_op("post_abort_mflo", 2'b10, 2'b00, 5'b10111, 32'd0, 32'd0, 5'd0, 32'd0, 5'd4, 5'd0);

      for (int i = 0; i < 60; i++) begin
         op = int'($urandom_range(0, 7));
         ex = {1'($urandom), 1'($urandom), 3'(op)};
         if (op == 6)
            do_mult("rnd_multu", ex, $urandom, $urandom, $urandom, 1'($urandom));
         else
            do_op("rnd_op", 2'($urandom), 2'($urandom), ex, $urandom, $urandom,
                  5'($urandom), $urandom, 5'($urandom), 5'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
